exec_unit: RTL and testbench

Parametrised execute unit for the RV32I core: a registered XLEN-wide ALU that keeps the existing 4-bit ALU operation encoding and adds iterative M-extension multiply/divide behind a valid/ready handshake. It replaces the purely combinational ALU path between register-file read and data-memory/writeback. Multi-cycle operations stall issue via `in_ready`. A `zero` flag is returned with every result for branch resolution.

---
 rtl/exec_pkg.sv | 39 +++
 rtl/exec_unit_iter_muldiv.sv | 112 +++++++++++
 rtl/exec_unit.sv | 131 +++++++++++++
 tb/tb_exec_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - op encoding and FSM state type for the RV32I execute unit
package exec_pkg;

  // ALU op encoding, shared with the ControlUnit ALUControl field
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_PASS = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } exec_state_t;

  // Single-cycle ops occupy the low end of the encoding
  function automatic logic op_is_alu(input logic [3:0] op);
    return op <= OP_SRA;
  endfunction

  // Ops that work on operand magnitudes and fix the sign afterwards
  function automatic logic op_is_signed_md(input logic [3:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/exec_unit_iter_muldiv.sv
// rtl/exec_unit_iter_muldiv.sv - shared iterative shift-add multiplier / restoring divider
module iter_muldiv
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN) + 1;

  // r_acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_dvs;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_op;
  logic              r_busy;
  logic              r_neg_res;
  logic              r_neg_rem;

  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_start_div;
  logic              w_is_div;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  assign w_signed    = op_is_signed_md(i_op);
  assign w_a_neg     = w_signed & i_a[XLEN-1];
  assign w_b_neg     = w_signed & i_b[XLEN-1];
  assign w_a_mag     = w_a_neg ? -i_a : i_a;
  assign w_b_mag     = w_b_neg ? -i_b : i_b;
  assign w_start_div = (i_op >= OP_DIV);
  assign w_is_div    = (r_op >= OP_DIV);
  assign o_done      = r_busy && (r_cnt == CW'(XLEN - 1));

  // One multiplier bit or one quotient bit per cycle
  always_comb begin
    w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_dvs} : '0);
    w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    // Only used when w_ge, where the true difference is below r_dvs and fits XLEN bits
    w_sub     = w_rem_sh[XLEN-1:0] - r_dvs;
    w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
    if (w_is_div) begin
      if (w_ge) begin
        w_acc_nxt = {w_sub, r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up applied to the final step; unsigned ops never set the negate flags
  always_comb begin
    w_prod_fix = r_neg_res ? -w_acc_nxt : w_acc_nxt;
    w_quo      = r_neg_res ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    w_rem      = r_neg_rem ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    o_result   = '0;
    case (r_op)
      OP_MUL:           o_result = w_prod_fix[XLEN-1:0];
      OP_MULH:          o_result = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:  o_result = w_quo;
      OP_REM, OP_REMU:  o_result = w_rem;
      default:          o_result = '0;
    endcase
  end

  // Operand latch on start, then XLEN iterations
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_busy    <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_cnt     <= '0;
      r_op      <= i_op;
      r_dvs     <= w_start_div ? w_b_mag : w_a_mag;
      r_acc     <= {{XLEN{1'b0}}, (w_start_div ? w_a_mag : w_b_mag)};
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - registered ALU with iterative M-extension behind valid/ready
module exec_unit
  import exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  exec_state_t     r_state;
  exec_state_t     w_state_nxt;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic [XLEN-1:0] w_result_nxt;
  logic [XLEN-1:0] w_alu;
  logic [SHW-1:0]  w_shamt;
  logic            w_md_start;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;

  assign w_shamt   = b[SHW-1:0];
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_zero;

  // Single-cycle ALU operations
  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_PASS: w_alu = b;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR:  w_alu = a ^ b;
      OP_SRL:  w_alu = a >> w_shamt;
      OP_SLL:  w_alu = a << w_shamt;
      OP_SRA:  w_alu = $signed(a) >>> w_shamt;
      default: w_alu = '0;
    endcase
  end

  generate
    if (MULDIV_EN) begin : g_muldiv
      iter_muldiv #(.XLEN(XLEN)) u_iter_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_md_done),
        .o_result (w_md_result)
      );
    end else begin : g_no_muldiv
      assign w_md_done   = 1'b0;
      assign w_md_result = '0;
    end
  endgenerate

  // Next state and next result; division corner cases bypass the iterator
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_md_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_DONE;
          if (op_is_alu(op)) begin
            w_result_nxt = w_alu;
          end else if (!MULDIV_EN) begin
            w_result_nxt = '0;
          end else if (op < OP_DIV) begin
            w_md_start  = 1'b1;
            w_state_nxt = ST_MUL;
          end else if (b == '0) begin
            w_result_nxt = ((op == OP_REM) || (op == OP_REMU)) ? a : '1;
          end else if (op_is_signed_md(op) && (a == MIN_NEG) && (b == '1)) begin
            w_result_nxt = (op == OP_DIV) ? a : '0;
          end else begin
            w_md_start  = 1'b1;
            w_state_nxt = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_md_done) begin
          w_result_nxt = w_md_result;
          w_state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, result and zero flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_zero   <= (w_result_nxt == '0);
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed self-checking bench for exec_unit
module tb_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks;
  int failures;

  exec_unit #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb);
    in_valid = 1'b1;
    op       = o;
    a        = xa;
    b        = xb;
    tick();
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] xa,
                     input logic [31:0] xb, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(o, xa, xb);
    chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    wait_done(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
    consume(tag);
  endtask

  initial begin
    int lat;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 4'b0000;
    a         = '0;
    b         = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd1);

    run("add", 4'b0000, 32'd7, 32'd5, 32'd12, 1);
    run("sub_zero", 4'b0001, 32'd5, 32'd5, 32'd0, 1);
    run("sra", 4'b1001, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1);
    run("slt", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run("sll", 4'b1000, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1);
    run("xor", 4'b0110, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1);
    run("mulh", 4'b1011, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    run("mul", 4'b1010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 33);
    run("mul_big", 4'b1010, 32'd12345, 32'd6789, 32'd83810205, 33);
    run("div", 4'b1100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem", 4'b1110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu", 4'b1101, 32'd100, 32'd7, 32'd14, 33);
    run("remu", 4'b1111, 32'd100, 32'd7, 32'd2, 33);
    run("divu_by0", 4'b1101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_by0", 4'b1110, 32'd7, 32'd0, 32'd7, 1);
    run("rem_ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run("div_ovf", 4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    issue(4'b0000, 32'd40, 32'd2);
    chk("hold_first_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op       = 4'b0000;
      a        = 32'd1;
      b        = 32'd1;
      tick();
      chk("hold_result", result, 32'd42);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    consume("hold");

    issue(4'b1101, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    chk("abort_busy", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      tick();
    end
    chk("abort_no_late_valid", {31'd0, out_valid}, 32'd0);
    run("add_after_abort", 4'b0000, 32'd3, 32'd4, 32'd7, 1);

    issue(4'b1100, 32'd50, 32'hFFFF_FFFB);
    wait_done(lat);
    chk("div_negb_latency", lat, 33);
    chk("div_negb_result", result, 32'hFFFF_FFF6);
    consume("div_negb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
